// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake, optional two-entry skid
// buffer, global stall hold and flush-to-bubble. Empty entries always carry ctrl=0.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic              ready_en;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic              main_valid, skid_valid;
    logic              push, pop;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);

    // ready_en keeps in_ready low until the first edge after reset release
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0)
            in_ready = ready_en & ~skid_valid & ~stall & ~flush;
        else
            in_ready = ready_en & (~main_valid | out_ready) & ~stall & ~flush;
    end

    assign out_valid = main_valid & ~stall & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_ctrl  = main_ctrl;
    assign out_data  = main_data;

    always_comb begin
        case (state)
            ONE:     occupancy = 2'd1;
            FULL:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            ready_en  <= 1'b0;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                // data registers intentionally keep their contents
                state     <= EMPTY;
                main_ctrl <= '0;
                skid_ctrl <= '0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (push) begin
                            main_ctrl <= in_ctrl;
                            main_data <= in_data;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && (pop || SKID == 0)) begin
                            main_ctrl <= in_ctrl;
                            main_data <= in_data;
                        end else if (push) begin
                            skid_ctrl <= in_ctrl;
                            skid_data <= in_data;
                            state     <= FULL;
                        end else if (pop) begin
                            main_ctrl <= '0;
                            state     <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            main_ctrl <= skid_ctrl;
                            main_data <= skid_data;
                            skid_ctrl <= '0;
                            state     <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance share stimulus and
// are compared each cycle against a small FIFO reference model.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, stall, flush, in_valid, out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          ir0, ov0, ir1, ov1;
    logic [CW-1:0] oc0, oc1;
    logic [DW-1:0] od0, od1;
    logic [1:0]    occ0, occ1;

    int checks = 0;
    int errors = 0;

    // reference model: per-instance FIFO contents, count and last head data
    logic [CW+DW-1:0] mem [2][2];
    int               cnt [2];
    logic [DW-1:0]    hd  [2];
    bit               rdy_en;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0), .out_data(od0),
        .occupancy(occ0)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1), .out_data(od1),
        .occupancy(occ1)
    );

    function automatic bit e_ready(int i);
        if (!rdy_en || !rst || stall || flush) return 1'b0;
        if (i == 1) return cnt[i] < 2;
        return (cnt[i] == 0) || out_ready;
    endfunction

    function automatic bit e_valid(int i);
        return (cnt[i] > 0) && !stall && !flush;
    endfunction

    function automatic logic [CW-1:0] e_ctrl(int i);
        logic [CW+DW-1:0] e;
        if (cnt[i] == 0) return '0;
        e = mem[i][0];
        return e[CW+DW-1:DW];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int i, input logic ir, input logic ov,
                             input logic [CW-1:0] oc, input logic [DW-1:0] od,
                             input logic [1:0] occ);
        chk($sformatf("s%0d_in_ready", i),  64'(ir),  64'(e_ready(i)));
        chk($sformatf("s%0d_out_valid", i), 64'(ov),  64'(e_valid(i)));
        chk($sformatf("s%0d_out_ctrl", i),  64'(oc),  64'(e_ctrl(i)));
        chk($sformatf("s%0d_out_data", i),  64'(od),  64'(hd[i]));
        chk($sformatf("s%0d_occupancy", i), 64'(occ), 64'(cnt[i]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0;
            hd[i]  = '0;
        end
        rdy_en = 1'b0;
    endtask

    // check outputs before the edge, then advance the model across it
    task automatic step();
        bit pu [2];
        bit po [2];
        #1;
        check_dut(0, ir0, ov0, oc0, od0, occ0);
        check_dut(1, ir1, ov1, oc1, od1, occ1);
        for (int i = 0; i < 2; i++) begin
            pu[i] = in_valid && e_ready(i);
            po[i] = e_valid(i) && out_ready;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                if (flush) begin
                    cnt[i] = 0;
                end else begin
                    if (po[i]) begin
                        mem[i][0] = mem[i][1];
                        cnt[i]--;
                    end
                    if (pu[i]) begin
                        mem[i][cnt[i]] = {in_ctrl, in_data};
                        cnt[i]++;
                    end
                end
                if (cnt[i] > 0) hd[i] = mem[i][0][DW-1:0];
            end
            rdy_en = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic reset_now();
        rst = 1'b0;
        #1;
        model_reset();
        check_dut(0, ir0, ov0, oc0, od0, occ0);
        check_dut(1, ir1, ov1, oc1, od1, occ1);
    endtask

    task automatic push_one(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = CW'($urandom_range(1, 255));
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ctrl = '0; in_data = '0;
        model_reset();
        #2;
        reset_now();
        @(negedge clk);
        step();
        rst = 1'b1;
        step();
        step();

        // streaming, one entry per cycle
        out_ready = 1'b1;
        for (int d = 1; d <= 16; d++) begin
            in_valid = 1'b1;
            in_data  = DW'(d);
            in_ctrl  = CW'($urandom_range(1, 255));
            step();
        end
        in_valid = 1'b0;
        step();

        // backpressure then stall
        out_ready = 1'b0;
        push_one(32'hA);
        push_one(32'hB);
        step();
        stall = 1'b1;
        repeat (3) step();
        stall = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        // flush with a full stage and an incoming entry
        out_ready = 1'b0;
        push_one(32'hA);
        push_one(32'hB);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hC; in_ctrl = 8'h5A;
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) step();

        // flush during stall
        out_ready = 1'b0;
        push_one(32'hD);
        push_one(32'hE);
        stall = 1'b1; flush = 1'b1;
        step();
        stall = 1'b0; flush = 1'b0;
        repeat (2) step();

        // simultaneous pop and push on the single-register variant
        out_ready = 1'b0;
        push_one(32'h11);
        step();
        out_ready = 1'b1;
        push_one(32'h12);
        step();

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 9) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            in_ctrl   = CW'($urandom);
            in_data   = DW'($urandom);
            step();
        end
        stall = 1'b0; flush = 1'b0; in_valid = 1'b0;

        // reset asserted with occupancy 2
        out_ready = 1'b0;
        push_one(32'h21);
        push_one(32'h22);
        in_valid = 1'b1; in_data = 32'h23;
        reset_now();
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        out_ready = 1'b1;
        push_one(32'h24);
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register that replaces the fixed-field stage latches between CPU pipeline stages with one generic block. It carries an opaque control vector and an opaque data vector from one stage to the next. It adds a valid/ready handshake, an optional two-entry skid buffer that registers the upstream ready, a global stall hold, and a flush that turns the stage into a bubble. Instances sit between IF/ID/EX/MEM/WB and at CPU-to-AXI-wrapper boundaries where the downstream side can backpressure.

## Interface
Parameters:
- DATA_W, 32: payload data width (ALU result, store data, instruction word packed by the instantiator).
- CTRL_W, 8: control vector width (RegWrite, MemRead, MemWrite, etc.). Zero means bubble.
- SKID, 1: 1 selects a two-entry skid buffer with in_ready decoupled from out_ready. 0 selects a single register with combinational ready.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous and active-low: asserting rst=0 resets immediately; release is synchronous to clk.
- stall  in  1  global CPU stall; while 1, no transfer occurs on either side and all state holds.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control vector.
- in_data  in  DATA_W  upstream data vector.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  presented control vector; all-zero whenever main entry is invalid.
- out_data  out  DATA_W  presented data vector.
- occupancy  out  2  number of valid entries (0..2, or 0..1 when SKID=0).

## Operation
- Storage: main entry (drives the out_* ports) and skid entry (present only when SKID=1). Each entry has a valid bit, ctrl and data.
- Handshake terms:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Output signals:
  - in_ready, SKID=1: !skid_valid & !stall & !flush.
  - in_ready, SKID=0: (!main_valid | out_ready) & !stall & !flush.
  - out_valid = main_valid & !stall & !flush.
- State machine, SKID=1:
  - EMPTY: push → ONE (main←in).
  - ONE:
    - push&pop → ONE (main←in).
    - push&!pop → FULL (skid←in).
    - !push&pop → EMPTY.
    - otherwise hold.
  - FULL: in_ready=0. pop → ONE (main←skid, skid invalid). Otherwise hold.
- SKID=0: states EMPTY/ONE only.
  - push → main←in, regardless of pop.
  - pop&!push → EMPTY.
- Ordering is strict FIFO; entries are never reordered or duplicated.
- Stall: all state holds, including data. in_ready and out_valid are forced 0, so no transfer can be counted.
- Flush has priority over stall and over push/pop:
  - Next edge: both valids ←0, main ctrl ←0, skid ctrl ←0.
  - Data registers keep their old values.
  - An in_valid presented in a flush cycle is dropped: in_ready=0.
- Empty entries always hold ctrl=0, so a bubble can never assert a write enable downstream.

## Timing
- Reset (rst=0) forces, asynchronously:
  - in_ready=0 (because of !rst gating; it rises the first cycle after release).
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - All skid state zero.
- Latency: 1 cycle. A push at edge N makes out_valid=1 after edge N.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- SKID=1:
  - in_ready depends only on registered state plus stall/flush; there is no combinational path from out_ready.
  - After one backpressure cycle, in_ready drops on the following cycle.
- occupancy updates on the same edge as the valid bits.
- Reset asserted mid-transfer discards all entries; no partial entry survives.

## Test plan
- Reset: rst=0 mid-stream with occupancy=2 → all outputs 0 immediately. After release, in_ready=1 within 1 cycle and occupancy=0.
- Streaming: in_valid=1, out_ready=1, data 0x1..0x10 on consecutive cycles → out_data 0x1..0x10 one cycle later, no gaps, occupancy=1 throughout.
- Backpressure, SKID=1: push 0xA, 0xB with out_ready=0 → occupancy=2 and in_ready=0. Raise out_ready → 0xA then 0xB, and in_ready=1 after the first pop.
- Stall: stall=1 for 3 cycles with occupancy=2 → out_valid=0 and in_ready=0. After release, 0xA then 0xB in order.
- Flush: flush=1 with occupancy=2 and in_valid=1 (0xC) → next cycle occupancy=0 and out_ctrl=0. 0xC never appears. Flush during stall also clears.
- SKID=0: out_ready=0 with entry held → in_ready=0. Then out_ready=1 and in_valid=1 in the same cycle → pop and push in one cycle, occupancy stays 1.
